// File: rtl/color_sensor_decoder_if.sv
// Signal bundle between a TCS3200-type colour sensor front end and its
// decoder.
//   enable       - measurement request (from the controlling logic)
//   sensor_out   - raw, asynchronous frequency output of the sensor
//   s2, s3       - sensor filter select bits (driven by the decoder)
//   color_select - detected colour: 00 OFF, 01 RED, 10 GREEN, 11 BLUE
//   color_valid  - one-cycle strobe when color_select is updated
//   busy         - measurement in progress
// Modports: slave = the decoder, master = whoever drives enable/sensor_out.
interface color_sensor_decoder_if;
    logic       enable;
    logic       sensor_out;
    logic       s2;
    logic       s3;
    logic [1:0] color_select;
    logic       color_valid;
    logic       busy;

    modport master (
        output enable,
        output sensor_out,
        input  s2,
        input  s3,
        input  color_select,
        input  color_valid,
        input  busy
    );

    modport slave (
        input  enable,
        input  sensor_out,
        output s2,
        output s3,
        output color_select,
        output color_valid,
        output busy
    );
endinterface

// File: rtl/color_sensor_decoder.sv
// Colour decoder for a TCS3200-type light-to-frequency sensor.
// A measurement steps the sensor filter through RED, GREEN and BLUE. For each
// filter it waits SETTLE cycles and then counts rising edges of the sensor
// output for WINDOW cycles. The largest count wins (ties: RED > GREEN > BLUE).
// A winner below THRESH reports OFF.
// Ports:
//   clk - system clock
//   rst - asynchronous active-high reset
//   bus - color_sensor_decoder_if.slave (enable, sensor_out in; s2, s3,
//         color_select, color_valid, busy out)
module color_sensor_decoder #(
    parameter int CNT_W  = 16,
    parameter int SETTLE = 1000,
    parameter int WINDOW = 50000,
    parameter int THRESH = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    color_sensor_decoder_if.slave  bus
);

    // One timer serves both the settle and the count intervals.
    localparam int TMR_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] THRESH_C    = CNT_W'(THRESH);

    localparam logic [1:0] COL_OFF   = 2'b00;
    localparam logic [1:0] COL_RED   = 2'b01;
    localparam logic [1:0] COL_GREEN = 2'b10;
    localparam logic [1:0] COL_BLUE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2,
        ST_DECIDE = 2'd3
    } state_t;

    // The phase value doubles as the index of the counter it feeds.
    typedef enum logic [1:0] {
        PH_RED   = 2'd0,
        PH_GREEN = 2'd1,
        PH_BLUE  = 2'd2
    } phase_t;

    state_t            state_reg, state_next;
    phase_t            phase_reg, phase_next;
    logic [TMR_W-1:0]  tmr_reg;
    logic              tmr_clr;
    logic              cnt_clr;
    logic              load_color;

    logic [1:0]        sync_reg;
    logic              prev_reg;
    logic              edge_reg;
    logic              count_en;

    logic [CNT_W-1:0]  cnt_q [3];
    logic [CNT_W-1:0]  win_cnt;
    logic [1:0]        win_color;
    logic [1:0]        color_select_reg;
    logic              color_valid_reg;

    // ------------------------------------------------------------------
    // Input conditioning: 2-flop synchronizer then registered edge detect.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
            edge_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], bus.sensor_out};
            prev_reg <= sync_reg[1];
            edge_reg <= sync_reg[1] & ~prev_reg;
        end
    end

    // ------------------------------------------------------------------
    // FSM state, phase and interval timer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            phase_reg <= PH_RED;
            tmr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            if (tmr_clr || state_reg == ST_IDLE)
                tmr_reg <= '0;
            else
                tmr_reg <= tmr_reg + TMR_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        tmr_clr    = 1'b0;
        cnt_clr    = 1'b0;
        load_color = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_next = ST_SETTLE;
                    phase_next = PH_RED;
                    tmr_clr    = 1'b1;
                    cnt_clr    = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_reg == SETTLE_LAST) begin
                    state_next = ST_COUNT;
                    tmr_clr    = 1'b1;
                end
            end
            ST_COUNT: begin
                if (tmr_reg == WINDOW_LAST) begin
                    tmr_clr = 1'b1;
                    case (phase_reg)
                        PH_RED: begin
                            state_next = ST_SETTLE;
                            phase_next = PH_GREEN;
                        end
                        PH_GREEN: begin
                            state_next = ST_SETTLE;
                            phase_next = PH_BLUE;
                        end
                        default: state_next = ST_DECIDE;
                    endcase
                end
            end
            ST_DECIDE: begin
                // Park the filter on RED so the idle sensor setting matches
                // the first phase of the next measurement.
                state_next = ST_IDLE;
                phase_next = PH_RED;
                load_color = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-filter saturating pulse counters.
    // ------------------------------------------------------------------
    assign count_en = (state_reg == ST_COUNT) && edge_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    cnt_reg <= '0;
                else if (cnt_clr)
                    cnt_reg <= '0;
                else if (count_en && phase_reg == 2'(gi) && cnt_reg != CNT_MAX)
                    cnt_reg <= cnt_reg + CNT_W'(1);
            end

            assign cnt_q[gi] = cnt_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Decision: a later colour must be strictly larger to take over, which
    // gives the RED > GREEN > BLUE tie priority.
    // ------------------------------------------------------------------
    always_comb begin
        win_cnt   = cnt_q[0];
        win_color = COL_RED;
        if (cnt_q[1] > win_cnt) begin
            win_cnt   = cnt_q[1];
            win_color = COL_GREEN;
        end
        if (cnt_q[2] > win_cnt) begin
            win_cnt   = cnt_q[2];
            win_color = COL_BLUE;
        end
        if (win_cnt < THRESH_C)
            win_color = COL_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_select_reg <= COL_OFF;
            color_valid_reg  <= 1'b0;
        end else begin
            color_valid_reg <= load_color;
            if (load_color)
                color_select_reg <= win_color;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Filter select is decoded from the phase register, so it
    // changes on the same edge that enters the new SETTLE interval.
    // ------------------------------------------------------------------
    always_comb begin
        bus.s2 = 1'b0;
        bus.s3 = 1'b0;
        case (phase_reg)
            PH_GREEN: begin
                bus.s2 = 1'b1;
                bus.s3 = 1'b1;
            end
            PH_BLUE: bus.s3 = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy         = (state_reg != ST_IDLE);
    assign bus.color_select = color_select_reg;
    assign bus.color_valid  = color_valid_reg;

endmodule

// File: tb/tb_color_sensor_decoder.sv
// Directed bench for color_sensor_decoder (SETTLE=10, WINDOW=100, THRESH=5).
// A second instance with CNT_W=4 exercises counter saturation.
module tb_color_sensor_decoder;

    localparam int SETTLE  = 10;
    localparam int WINDOW  = 100;
    localparam int THRESH  = 5;
    localparam int LAT     = 2 + 3 * (SETTLE + WINDOW);   // 332
    localparam int BUSY_N  = LAT - 1;                     // 331

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    color_sensor_decoder_if m_if ();
    color_sensor_decoder_if s_if ();

    color_sensor_decoder #(
        .CNT_W  (16),
        .SETTLE (SETTLE),
        .WINDOW (WINDOW),
        .THRESH (THRESH)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if.slave)
    );

    color_sensor_decoder #(
        .CNT_W  (4),
        .SETTLE (SETTLE),
        .WINDOW (WINDOW),
        .THRESH (THRESH)
    ) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (s_if.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Main sensor generator: period chosen by the current filter, with the
    // waveform restarted whenever busy or the filter changes so that equal
    // periods give identical counts in every phase.
    // ------------------------------------------------------------------
    int         pr = 0, pg = 0, pb = 0;
    logic       tog_mode = 1'b0;
    int         wcnt = 0;
    logic [2:0] key_prev = 3'b000;

    always @(negedge clk) begin : gen_main
        logic [2:0] key;
        int         p;
        key = {m_if.busy, m_if.s2, m_if.s3};
        if (key != key_prev) wcnt = 0;
        else                 wcnt = wcnt + 1;
        key_prev = key;
        case ({m_if.s2, m_if.s3})
            2'b00:   p = pr;
            2'b11:   p = pg;
            2'b01:   p = pb;
            default: p = 0;
        endcase
        if (tog_mode)    m_if.sensor_out = wcnt[0];
        else if (p == 0) m_if.sensor_out = 1'b0;
        else             m_if.sensor_out = ((wcnt % p) < (p / 2));
    end

    // Saturation generator: toggles every cycle (period 2) on selected filters.
    logic sat_r = 1'b0, sat_b = 1'b0, stog = 1'b0;

    always @(negedge clk) begin : gen_sat
        logic on;
        case ({s_if.s2, s_if.s3})
            2'b00:   on = sat_r;
            2'b01:   on = sat_b;
            default: on = 1'b0;
        endcase
        stog = ~stog;
        s_if.sensor_out = stog & on;
    end

    // One enable pulse on the main DUT, observed for 340 cycles.
    task automatic run_main(input string tag, input int r, input int g, input int b,
                            input logic [1:0] exp);
        int lat, busy_n, strobes;
        pr = r; pg = g; pb = b;
        lat = 0; busy_n = 0; strobes = 0;
        @(negedge clk);
        m_if.enable = 1'b1;
        @(posedge clk);
        #1 m_if.enable = 1'b0;
        for (int j = 0; j < 340; j++) begin
            @(negedge clk);
            if (m_if.busy) busy_n++;
            if (m_if.color_valid) begin
                strobes++;
                if (lat == 0) lat = j + 1;
            end
            if (j == 0)   check({tag, "_flt_red"},   {m_if.s2, m_if.s3}, 2'b00);
            if (j == 120) check({tag, "_flt_green"}, {m_if.s2, m_if.s3}, 2'b11);
            if (j == 230) check({tag, "_flt_blue"},  {m_if.s2, m_if.s3}, 2'b01);
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_busy_cycles"}, busy_n, BUSY_N);
        check({tag, "_strobes"}, strobes, 1);
        check({tag, "_color"}, m_if.color_select, exp);
        $display("vector %s: periods %0d/%0d/%0d color=%0d latency=%0d busy=%0d strobes=%0d",
                 tag, r, g, b, m_if.color_select, lat, busy_n, strobes);
    endtask

    task automatic run_sat(input string tag, input logic r, input logic b, input logic [1:0] exp);
        int lat;
        logic [1:0] col;
        sat_r = r; sat_b = b;
        lat = 0; col = 2'b00;
        @(negedge clk);
        s_if.enable = 1'b1;
        @(posedge clk);
        #1 s_if.enable = 1'b0;
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            if (s_if.color_valid && lat == 0) begin
                lat = j + 1;
                col = s_if.color_select;
            end
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_color"}, col, exp);
        $display("vector %s: color=%0d latency=%0d", tag, col, lat);
        sat_r = 1'b0; sat_b = 1'b0;
    endtask

    // Directed vectors: per-phase sensor period (0 = held low), expected colour.
    int         vr [8] = '{4, 0, 8, 20, 20, 0, 40, 16};
    int         vg [8] = '{20, 0, 8, 4, 20, 8, 0, 0};
    int         vb [8] = '{20, 0, 0, 20, 4, 8, 0, 0};
    logic [1:0] vc [8] = '{2'b01, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01};
    string      vn [8] = '{"red_dom", "dark", "tie_rg", "green_dom", "blue_dom",
                           "tie_gb", "below_thr", "above_thr"};

    initial begin
        logic [4:0] acc;
        int         lat1, lat2, strobes;
        logic       busy_after;

        m_if.enable = 1'b0;
        s_if.enable = 1'b0;

        // Reset with a toggling sensor: every output must stay low.
        tog_mode = 1'b1;
        acc = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = acc | {m_if.busy, m_if.color_valid, m_if.color_select, m_if.s2 | m_if.s3};
        end
        check("rst_busy",  32'(acc[4]),   0);
        check("rst_valid", 32'(acc[3]),   0);
        check("rst_color", 32'(acc[2:1]), 0);
        check("rst_filter", 32'(acc[0]),  0);
        $display("vector reset: outputs or-ed=%b", acc);
        tog_mode = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 8; v++)
            run_main(vn[v], vr[v], vg[v], vb[v], vc[v]);

        // Reset during COUNT/GREEN: outputs clear at once, no strobe follows.
        pr = 4; pg = 4; pb = 4;
        @(negedge clk);
        m_if.enable = 1'b1;
        @(posedge clk);
        #1 m_if.enable = 1'b0;
        for (int j = 0; j < 150; j++) @(negedge clk);
        check("midrst_pre_filter", {m_if.s2, m_if.s3}, 2'b11);
        check("midrst_pre_busy", m_if.busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_busy",   m_if.busy, 0);
        check("midrst_color",  m_if.color_select, 0);
        check("midrst_filter", {m_if.s2, m_if.s3}, 2'b00);
        acc = '0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            acc[0] = acc[0] | m_if.color_valid;
        end
        check("midrst_valid", 32'(acc[0]), 0);
        $display("vector mid_reset: busy=%0d color=%0d", m_if.busy, m_if.color_select);
        rst = 1'b0;
        @(negedge clk);
        run_main("post_rst", 4, 20, 20, 2'b01);

        // Back-to-back: enable held high, dropped during the second run.
        pr = 4; pg = 20; pb = 20;
        lat1 = 0; lat2 = 0; strobes = 0; busy_after = 1'b0;
        @(negedge clk);
        m_if.enable = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 700; j++) begin
            @(negedge clk);
            if (j == 400) m_if.enable = 1'b0;
            if (j == LAT) busy_after = m_if.busy;
            if (m_if.color_valid) begin
                strobes++;
                if (lat1 == 0)      lat1 = j + 1;
                else if (lat2 == 0) lat2 = j + 1;
            end
        end
        check("b2b_lat1", lat1, LAT);
        check("b2b_restart_busy", busy_after, 1);
        check("b2b_lat2", lat2, 2 * LAT);
        check("b2b_strobes", strobes, 2);
        check("b2b_color", m_if.color_select, 2'b01);
        $display("vector back_to_back: lat1=%0d lat2=%0d strobes=%0d", lat1, lat2, strobes);

        // CNT_W=4: 50 edges must clamp at 15 rather than wrap to 2.
        run_sat("sat_blue", 1'b0, 1'b1, 2'b11);
        run_sat("sat_tie_rb", 1'b1, 1'b1, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
